// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding and compare-bit positions for alu_pipe
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_CMP = 2'd2,
    ALU_AND = 2'd3
  } alu_op_t;

  localparam int CMP_GT_BIT = 0;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_LT_BIT = 2;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational add/sub/compare/AND; zero/ovf flags only with ALU_PIPE_FLAGS_EN
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: {carry, result} = w_sum;
      ALU_SUB: {carry, result} = w_diff;
      ALU_CMP: begin
        result[CMP_GT_BIT] = (a > b);
        result[CMP_EQ_BIT] = (a == b);
        result[CMP_LT_BIT] = (a < b);
      end
      ALU_AND: result = a & b;
      default: result = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  assign zero = (result == '0);

  always_comb begin
    ovf = 1'b0;
    case (op)
      ALU_ADD: ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline; flags registered only with ALU_PIPE_FLAGS_EN
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  logic             r_v1;
  alu_op_t          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_v2;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  logic             w_adv1;
  logic             w_adv2;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_zero;
  logic             w_ovf;

  // A stage may load when it is empty or the stage after it is draining.
  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_op <= ALU_ADD;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_op <= alu_op_t'(op);
        r_a  <= a;
        r_b  <= b;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .result (w_result),
    .carry  (w_carry),
    .zero   (w_zero),
    .ovf    (w_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_result <= w_result;
        r_carry  <= w_carry;
      end
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic r_zero;
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_adv2 && r_v1) begin
      r_zero <= w_zero;
      r_ovf  <= w_ovf;
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`else
  // Core drives constant zeros here, so the ports stay tied low.
  assign zero = w_zero;
  assign ovf  = w_ovf;
`endif

  assign out_valid = r_v2;
  assign result    = r_result;
  assign carry     = r_carry;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         ovf;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int cy;
    int zf;
    int of;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_bp = 1'b0;

  function automatic exp_t model(input int o, input int x, input int y);
    exp_t e;
    int m    = 1 << W;
    int half = m / 2;
    int sx   = (x >= half) ? x - m : x;
    int sy   = (y >= half) ? y - m : y;
    int sv   = 0;
    e.cy = 0;
    e.of = 0;
    case (o)
      0: begin
        e.res = (x + y) % m;
        e.cy  = (x + y >= m) ? 1 : 0;
        sv    = sx + sy;
        e.of  = (sv < -half || sv >= half) ? 1 : 0;
      end
      1: begin
        e.res = (x - y + m) % m;
        e.cy  = (x >= y) ? 1 : 0;
        sv    = sx - sy;
        e.of  = (sv < -half || sv >= half) ? 1 : 0;
      end
      2: e.res = (x > y) ? 1 : ((x == y) ? 2 : 4);
      default: e.res = x & y;
    endcase
`ifdef ALU_PIPE_FLAGS_EN
    e.zf = (e.res == 0) ? 1 : 0;
`else
    e.zf = 0;
    e.of = 0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pack_out();
    return {26'd0, out_valid, result, carry, zero};
  endfunction

  // Monitor: every output transfer pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", int'(result), e.res);
        check("carry", int'(carry), e.cy);
        check("flags", int'({zero, ovf}), e.zf * 2 + e.of);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer.
  task automatic send(input int o, input int x, input int y);
    int  n = 0;
    bit  done = 1'b0;
    op = 2'(o);
    a = W'(x);
    b = W'(y);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(o, x, y));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        check("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  int ops_o[3] = '{0, 1, 3};
  int ops_a[3] = '{6, 12, 13};
  int ops_b[3] = '{7, 3, 11};

  initial begin
    int idx;
    int acc;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", pack_out() * 2 + int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", int'(in_ready), 1);
    @(posedge clk);
    #1;

    send(0, 9, 8);
    send(1, 3, 5);
    send(1, 5, 5);
    send(2, 7, 7);
    send(2, 2, 9);
    send(3, 12, 10);
    send(0, 15, 1);
    send(1, 0, 0);
    send(0, 7, 1);
    send(1, 8, 1);
    drain();

    // Backpressure: three back-to-back offers with the consumer stalled.
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      op = 2'(ops_o[idx]);
      a  = W'(ops_a[idx]);
      b  = W'(ops_b[idx]);
      @(negedge clk);
      if (in_ready && idx < 3) begin
        exp_q.push_back(model(ops_o[idx], ops_a[idx], ops_b[idx]));
        idx++;
        acc++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc, 2);
    @(negedge clk);
    check("bp_in_ready_low", int'(in_ready), 0);

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stable_valid", int'(out_valid), 1);
      check("stable_result", int'(result), exp_q[0].res);
      check("stable_carry", int'(carry), exp_q[0].cy);
      check("stable_flags", int'({zero, ovf}), exp_q[0].zf * 2 + exp_q[0].of);
    end

    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pass_in_ready", int'(in_ready), 1);
    if (in_ready) exp_q.push_back(model(ops_o[2], ops_a[2], ops_b[2]));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Async reset with two transactions stalled inside.
    out_ready = 1'b0;
    send(0, 3, 4);
    send(3, 15, 6);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", pack_out() * 2 + int'(ovf), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Inputs launched after edge k: result must be visible after edge k+2.
    op = 2'd0;
    a = W'(1);
    b = W'(1);
    in_valid = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    if (in_ready) exp_q.push_back(model(0, 1, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_not_early", int'(out_valid), 0);
    @(negedge clk);
    check("latency_2", int'(out_valid), 1);
    check("post_rst_sum", int'(result), 2);
    @(posedge clk);
    #1;
    drain();

    // Randomised traffic with random consumer stalls.
    rand_bp = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int sel_a = $urandom_range(0, 3);
          int sel_b = $urandom_range(0, 3);
          int x = (sel_a == 0) ? 0 : ((sel_a == 1) ? (1 << W) - 1 : $urandom_range(0, (1 << W) - 1));
          int y = (sel_b == 0) ? 0 : ((sel_b == 1) ? (1 << W) - 1 : $urandom_range(0, (1 << W) - 1));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send($urandom_range(0, 3), x, y);
        end
        rand_bp = 1'b0;
      end
      begin
        while (rand_bp) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
